// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 8x8 RGB332 matrix scanner with row fetch, blanking and 8-step PWM.
// Define SCAN_GAMMA_EN to pass duty values through a gamma LUT before the PWM compare.
module led_matrix_scan #(
    parameter int MATRIX_SIZE     = 8,
    parameter int ADDR_WIDTH      = 6,
    parameter int COLOR_DEPTH     = 8,
    parameter int PWM_STEP_CYCLES = 64,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [COLOR_DEPTH-1:0] pixel_data,
    output logic [ADDR_WIDTH-1:0]  read_addr,
    output logic [MATRIX_SIZE-1:0] row_sel,
    output logic [MATRIX_SIZE-1:0] col_r,
    output logic [MATRIX_SIZE-1:0] col_g,
    output logic [MATRIX_SIZE-1:0] col_b,
    output logic                   frame_start,
    output logic                   scan_active
);

    typedef enum logic [1:0] {IDLE, FETCH, BLANK, DISPLAY} state_e;

    localparam logic [15:0] STEP_LAST  = 16'(PWM_STEP_CYCLES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [7:0]  blank_q, blank_d;
    logic [15:0] step_q, step_d;
    logic [2:0]  pwm_q, pwm_d;
    logic [5:0]  addr_q;
    logic [7:0]  line_q [8];
    logic [7:0]  row_sel_q, row_sel_d;
    logic [7:0]  col_r_q, col_r_d;
    logic [7:0]  col_g_q, col_g_d;
    logic [7:0]  col_b_q, col_b_d;
    logic        frame_q, frame_d;

    function automatic logic [2:0] shape(input logic [2:0] d);
`ifdef SCAN_GAMMA_EN
        logic [2:0] g;
        case (d)
            3'd0:    g = 3'd0;
            3'd1:    g = 3'd1;
            3'd2:    g = 3'd1;
            3'd3:    g = 3'd2;
            3'd4:    g = 3'd3;
            3'd5:    g = 3'd4;
            3'd6:    g = 3'd5;
            default: g = 3'd7;
        endcase
        return g;
`else
        return d;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            blank_q   <= '0;
            step_q    <= '0;
            pwm_q     <= '0;
            addr_q    <= '0;
            row_sel_q <= '0;
            col_r_q   <= '0;
            col_g_q   <= '0;
            col_b_q   <= '0;
            frame_q   <= 1'b0;
            for (int i = 0; i < 8; i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            blank_q   <= blank_d;
            step_q    <= step_d;
            pwm_q     <= pwm_d;
            row_sel_q <= row_sel_d;
            col_r_q   <= col_r_d;
            col_g_q   <= col_g_d;
            col_b_q   <= col_b_d;
            frame_q   <= frame_d;
            if (state_q == FETCH) begin
                addr_q        <= {row_q, col_q};
                line_q[col_q] <= pixel_data[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        blank_d = blank_q;
        step_d  = step_q;
        pwm_d   = pwm_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FETCH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            FETCH: begin
                col_d = col_q + 3'd1;
                if (col_q == 3'd7) begin
                    state_d = BLANK;
                    blank_d = '0;
                end
            end
            BLANK: begin
                blank_d = blank_q + 8'd1;
                if (blank_q == BLANK_LAST) begin
                    state_d = DISPLAY;
                    step_d  = '0;
                    pwm_d   = '0;
                end
            end
            DISPLAY: begin
                step_d = step_q + 16'd1;
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    pwm_d  = pwm_q + 3'd1;
                    if (pwm_q == 3'd7) begin
                        row_d   = row_q + 3'd1;
                        col_d   = '0;
                        state_d = enable ? FETCH : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drives are registered: compute them from the state being entered.
    always_comb begin
        row_sel_d = '0;
        col_r_d   = '0;
        col_g_d   = '0;
        col_b_d   = '0;
        frame_d   = (state_d == FETCH) && (state_q != FETCH) &&
                    (row_d == 3'd0);
        if (state_d == DISPLAY) begin
            row_sel_d = 8'd1 << row_q;
            for (int c = 0; c < 8; c++) begin
                col_r_d[c] = pwm_d < shape(line_q[c][7:5]);
                col_g_d[c] = pwm_d < shape(line_q[c][4:2]);
                col_b_d[c] = pwm_d < shape({line_q[c][1:0], line_q[c][1]});
            end
        end
    end

    assign read_addr   = (state_q == FETCH) ? {row_q, col_q} : addr_q;
    assign row_sel     = row_sel_q;
    assign col_r       = col_r_q;
    assign col_g       = col_g_q;
    assign col_b       = col_b_q;
    assign frame_start = frame_q;
    assign scan_active = (state_q != IDLE);

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of fetch order, blanking, PWM duty,
// row walk, frame timing, mid-scan reset and enable drop.
module tb_led_matrix_scan;

    localparam int PSC  = 2;
    localparam int BLK  = 4;
    localparam int ROWP = 8 + BLK + 8 * PSC;
    localparam int FRMP = 8 * ROWP;
    localparam int NTR  = 250;
`ifdef SCAN_GAMMA_EN
    localparam int R5_CYC = 8;
    localparam int B1_CYC = 2;
`else
    localparam int R5_CYC = 10;
    localparam int B1_CYC = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] pixel_data;
    logic [5:0] read_addr;
    logic [7:0] row_sel;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic [7:0] col_b;
    logic       frame_start;
    logic       scan_active;

    logic [7:0] fb [64];
    int n_vec = 0;
    int n_err = 0;

    logic [5:0] tr_addr [NTR];
    logic [7:0] tr_row  [NTR];
    logic [7:0] tr_r    [NTR];
    logic [7:0] tr_g    [NTR];
    logic [7:0] tr_b    [NTR];
    logic       tr_fs   [NTR];

    always #5 clk = ~clk;

    assign pixel_data = fb[read_addr];

    led_matrix_scan #(
        .MATRIX_SIZE(8),
        .ADDR_WIDTH(6),
        .COLOR_DEPTH(8),
        .PWM_STEP_CYCLES(PSC),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pixel_data(pixel_data),
        .read_addr(read_addr),
        .row_sel(row_sel),
        .col_r(col_r),
        .col_g(col_g),
        .col_b(col_b),
        .frame_start(frame_start),
        .scan_active(scan_active)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        int c_blank_row, c_blank_col, c_r1sel;
        int c_r0, c_g1, c_b2, c_b3, c_r4, c_r7, c_g7, c_r1;
        int c_ff, c_00, c_gb, n_fs, fs2, s, cnt8, cnt16;
        bit done;

        for (int i = 0; i < 64; i++) fb[i] = 8'hE0;
        fb[0] = 8'h20;
        fb[1] = 8'h1C;
        fb[2] = 8'h03;
        fb[3] = 8'h01;
        fb[4] = 8'hA0;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(read_addr), 32'h0);
        check("rst_row", 32'(row_sel), 32'h0);
        check("rst_cols", {8'h0, col_r, col_g, col_b}, 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_act", 32'(scan_active), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", 32'(scan_active), 32'h0);

        enable = 1'b1;
        for (int i = 0; i < NTR; i++) begin
            @(negedge clk);
            tr_addr[i] = read_addr;
            tr_row[i]  = row_sel;
            tr_r[i]    = col_r;
            tr_g[i]    = col_g;
            tr_b[i]    = col_b;
            tr_fs[i]   = frame_start;
        end

        check("fs_first", 32'(tr_fs[0]), 32'h1);
        for (int k = 0; k < 8; k++) begin
            check("addr_row0", 32'(tr_addr[k]), 32'(k));
            check("addr_row1", 32'(tr_addr[ROWP + k]), 32'(8 + k));
        end

        c_blank_row = 0;
        c_blank_col = 0;
        for (int i = 0; i < 12; i++) begin
            if (tr_row[i] != 8'h00) c_blank_row++;
            if ((tr_r[i] | tr_g[i] | tr_b[i]) != 8'h00) c_blank_col++;
        end
        check("fetch_blank_row", 32'(c_blank_row), 32'h0);
        check("fetch_blank_col", 32'(c_blank_col), 32'h0);

        c_r1sel = 0; c_r0 = 0; c_g1 = 0; c_b2 = 0; c_b3 = 0;
        c_r4 = 0; c_r7 = 0; c_g7 = 0; c_r1 = 0;
        for (int i = 0; i < ROWP; i++) begin
            if (tr_row[i] == 8'h01) c_r1sel++;
            c_r0 += int'(tr_r[i][0]);
            c_g1 += int'(tr_g[i][1]);
            c_b2 += int'(tr_b[i][2]);
            c_b3 += int'(tr_b[i][3]);
            c_r4 += int'(tr_r[i][4]);
            c_r7 += int'(tr_r[i][7]);
            c_g7 += int'(tr_g[i][7]);
            c_r1 += int'(tr_r[i][1]);
        end
        check("row0_sel_cycles", 32'(c_r1sel), 32'd16);
        check("r0_duty", 32'(c_r0), 32'd2);
        check("g1_duty", 32'(c_g1), 32'd14);
        check("b2_duty", 32'(c_b2), 32'd14);
        check("b3_duty", 32'(c_b3), 32'(B1_CYC));
        check("r4_duty", 32'(c_r4), 32'(R5_CYC));
        check("r7_duty", 32'(c_r7), 32'd14);
        check("g7_off", 32'(c_g7), 32'd0);
        check("r1_off", 32'(c_r1), 32'd0);

        c_ff = 0; c_00 = 0; c_gb = 0;
        for (int i = ROWP; i < 2 * ROWP; i++) begin
            if (tr_row[i] == 8'h02 && tr_r[i] == 8'hFF) c_ff++;
            if (tr_row[i] == 8'h02 && tr_r[i] == 8'h00) c_00++;
            if ((tr_g[i] | tr_b[i]) != 8'h00) c_gb++;
        end
        check("row1_red_on", 32'(c_ff), 32'd14);
        check("row1_red_off", 32'(c_00), 32'd2);
        check("row1_gb_off", 32'(c_gb), 32'd0);

        for (int k = 0; k < 8; k++)
            check("row_walk", 32'(tr_row[12 + k * ROWP]), 32'(1) << k);
        check("row_wrap", 32'(tr_row[FRMP + 12]), 32'h01);

        n_fs = 0;
        fs2  = -1;
        for (int i = 0; i < NTR; i++) begin
            if (tr_fs[i]) begin
                n_fs++;
                if (i > 0 && fs2 < 0) fs2 = i;
            end
        end
        check("fs_count", 32'(n_fs), 32'd2);
        check("fs_period", 32'(fs2), 32'(FRMP));

        @(negedge clk);
        check("pre_rst_disp", 32'(row_sel), 32'h01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_outs", {2'b0, read_addr, row_sel, col_r, col_g, col_b},
              32'h0);
        check("mid_rst_misc", {30'h0, frame_start, scan_active}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_fs", 32'(frame_start), 32'h1);
        check("restart_addr", 32'(read_addr), 32'h0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("restart_seq", 32'(read_addr), 32'(k));
        end
        check("restart_fs_end", 32'(frame_start), 32'h0);

        s     = 7;
        cnt8  = 0;
        cnt16 = 0;
        done  = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            s++;
            if (s == 100) enable = 1'b0;
            if (row_sel == 8'h08) cnt8++;
            if (row_sel == 8'h10) cnt16++;
            if (!scan_active) begin
                done = 1'b1;
                break;
            end
        end
        check("drop_idle_reached", 32'(done), 32'h1);
        check("drop_idle_time", 32'(s), 32'd112);
        check("drop_row3_cycles", 32'(cnt8), 32'd16);
        check("drop_no_row4", 32'(cnt16), 32'd0);
        check("drop_idle_outs", {8'h0, row_sel, col_r | col_g | col_b,
              7'h0, frame_start}, 32'h0);
        repeat (5) @(negedge clk);
        check("drop_idle_hold", 32'(scan_active), 32'h0);

        enable = 1'b1;
        @(negedge clk);
        check("reen_fs", 32'(frame_start), 32'h1);
        check("reen_addr", 32'(read_addr), 32'h0);
        check("reen_row", 32'(row_sel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
